// File: rtl/fas_serial_ctrl.sv
// fas_serial_ctrl: bit-serial add/subtract sequencer.
// One full adder/subtractor step per clock, LSB first. The carry/borrow is held
// in a flip-flop between steps. The finished word, carry/borrow and signed
// overflow are published together on the last step and then held until the
// next completion.
module fas_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         a_ns,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         abort,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  // Counter only needs to reach N-1; the extra bit keeps N=1 and powers of two simple.
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;

  logic [N-1:0]  a_sh, b_sh, res_sh;
  logic          carry;
  logic          add_q;
  logic          a_msb, b_msb;
  logic [CW-1:0] cnt;

  logic          sum_bit;
  logic          carry_nxt;
  logic          last_bit;
  logic [N-1:0]  res_nxt;

  // Single-bit adder/subtractor cell and the result shift-in from the MSB side.
  always_comb begin
    sum_bit = a_sh[0] ^ b_sh[0] ^ carry;
    if (add_q) begin
      carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end else begin
      carry_nxt = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & carry) | (b_sh[0] & carry);
    end
    // Written as shift-and-or so the expression stays legal for N=1.
    res_nxt  = (res_sh >> 1) | (N'(sum_bit) << (N - 1));
    last_bit = (cnt == CW'(N - 1));
  end

  // Next-state decode.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_bit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, serial datapath and published outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      add_q  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sh   <= a;
        b_sh   <= b;
        res_sh <= '0;
        carry  <= 1'b0;
        add_q  <= a_ns;
        a_msb  <= a[N-1];
        b_msb  <= b[N-1];
        cnt    <= '0;
      end else if (state == RUN && !abort) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_nxt;
        carry  <= carry_nxt;
        cnt    <= cnt + CW'(1);
        if (last_bit) begin
          result <= res_nxt;
          cout   <= carry_nxt;
          // Overflow judged from the captured operand sign bits and the new result sign.
          if (add_q) ovf <= (a_msb == b_msb) && (res_nxt[N-1] != a_msb);
          else       ovf <= (a_msb != b_msb) && (res_nxt[N-1] != a_msb);
        end
      end
    end
  end

  // Handshake outputs decode from state only.
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule
